// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, writes it as 32-bit words into instruction memory, and checks its checksum
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  input  logic        start_i,
  output logic [31:0] addr_imem_ram_o,
  output logic [31:0] wr_instr_imem_ram_o,
  output logic        wr_en_imem_ram_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);
  typedef enum logic [2:0] {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_len, r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_csum;
  logic [23:0] r_word;
  logic [31:0] r_addr, r_instr;
  logic        r_wr_en;
  logic        w_acc, w_last_byte, w_last_word, w_rearm;
  logic [15:0] w_len;

  assign byte_ready_o = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_acc        = byte_valid_i & byte_ready_o;
  assign w_len        = {r_len[15:8], byte_data_i};
  assign w_last_byte  = r_byte_idx == 2'd3;
  assign w_last_word  = (r_word_idx + 16'd1) == r_len;
  assign w_rearm      = start_i && (r_state == S_DONE || r_state == S_ERR);

  // State register; reset forces the length-high state immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_LEN_HI;
    else        r_state <= w_next;
  end

  // Next-state and status outputs
  always_comb begin
    w_next     = r_state;
    cpu_hold_o = 1'b1;
    done_o     = 1'b0;
    err_o      = 1'b0;
    case (r_state)
      S_LEN_HI: if (w_acc) w_next = S_LEN_LO;
      S_LEN_LO: if (w_acc) w_next = (32'(w_len) > MAX_WORDS) ? S_ERR : (w_len == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:   if (w_acc && w_last_byte && w_last_word) w_next = S_CSUM;
      S_CSUM:   if (w_acc) w_next = (byte_data_i == r_csum) ? S_DONE : S_ERR;
      S_DONE: begin
        cpu_hold_o = 1'b0;
        done_o     = 1'b1;
        if (start_i) w_next = S_LEN_HI;
      end
      S_ERR: begin
        err_o = 1'b1;
        if (start_i) w_next = S_LEN_HI;
      end
      default: w_next = S_LEN_HI;
    endcase
  end

  // Length capture, word assembly, checksum and the one-cycle memory write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_csum     <= '0;
      r_word     <= '0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_wr_en    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_rearm) begin
        r_word_idx <= '0;
        r_byte_idx <= '0;
        r_csum     <= '0;
      end else if (w_acc) begin
        if (r_state == S_LEN_HI) r_len[15:8] <= byte_data_i;
        if (r_state == S_LEN_LO) r_len[7:0] <= byte_data_i;
        if (r_state == S_DATA) begin
          r_csum     <= r_csum ^ byte_data_i;
          r_byte_idx <= r_byte_idx + 2'd1;
          r_word     <= {r_word[15:0], byte_data_i};
          if (w_last_byte) begin
            r_wr_en    <= 1'b1;
            r_instr    <= {r_word, byte_data_i};
            r_addr     <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
            r_word_idx <= r_word_idx + 16'd1;
          end
        end
      end
    end
  end

  assign addr_imem_ram_o     = r_addr;
  assign wr_instr_imem_ram_o = r_instr;
  assign wr_en_imem_ram_o    = r_wr_en;
endmodule
